// File: rtl/reg_writeback_pkg.sv
// Shared types for the write-back sequencer: register index, data word,
// queue entry layout and register-file write strobe encodings.
package reg_writeback_pkg;

    localparam int unsigned WORD_W = 16;

    typedef logic [1:0]        reg_idx_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        reg_idx_t num;
        word_t    data;
        logic     hi;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_NONE = 2'b00,
        WB_LO   = 2'b01,
        WB_HI   = 2'b10
    } wb_write_t;

endpackage

// File: rtl/reg_writeback_fifo.sv
// wb_fifo: circular result queue with single/double push and single pop.
// The second word of a double push is always the high half of a pair.
module wb_fifo
    import reg_writeback_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             push_two,
    input  reg_idx_t         num0,
    input  logic [WIDTH-1:0] data0,
    input  reg_idx_t         num1,
    input  logic [WIDTH-1:0] data1,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_nxt,
    output reg_idx_t         head_num,
    output logic [WIDTH-1:0] head_data,
    output logic             head_hi
);

    reg_idx_t         num_mem  [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic             hi_mem   [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tail_p1;
    logic [CNT_W-1:0] push_n;

    always_comb begin
        tail_p1   = tail + PTR_W'(1);
        push_n    = '0;
        if (push)
            push_n = push_two ? CNT_W'(2) : CNT_W'(1);
        count_nxt = count + push_n - CNT_W'(pop);
        head_num  = num_mem[head];
        head_data = data_mem[head];
        head_hi   = hi_mem[head];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop)
                head <= head + PTR_W'(1);
            if (push)
                tail <= push_two ? tail + PTR_W'(2) : tail_p1;
            count <= count_nxt;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            num_mem[tail]  <= num0;
            data_mem[tail] <= data0;
            hi_mem[tail]   <= 1'b0;
            if (push_two) begin
                num_mem[tail_p1]  <= num1;
                data_mem[tail_p1] <= data1;
                hi_mem[tail_p1]   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Write-back sequencer: queues execute results, arbitrates the shared register
// file ports against decode reads, tracks pending writes. Option: WB_BYPASS_EN.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_num,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_pair,
    input  logic [WIDTH-1:0] in_data_hi,
    input  logic             rd_req,
    input  logic [1:0]       rd_num1,
    input  logic [1:0]       rd_num2,
    output logic             rd_grant,
    output logic [WIDTH-1:0] wb_data,
    output logic [1:0]       wb_write,
    output logic [1:0]       wb_num1,
    output logic [1:0]       wb_num2,
    output logic [3:0]       pending
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    reg_idx_t         head_num;
    logic [WIDTH-1:0] head_data;
    logic             head_hi;

    logic      accept;
    logic      bypass;
    logic      push;
    logic      read_win;
    logic      do_pop;
    wb_write_t wtype;

    logic [CNT_W-1:0] sb_cnt [4];
    logic [CNT_W-1:0] sb_nxt [4];
    logic [3:0]       sb_inc;
    logic [3:0]       sb_dec;

    assign accept = in_valid && in_ready;

`ifdef WB_BYPASS_EN
    assign bypass = accept && !in_pair && !rd_req && (count == '0);
`else
    assign bypass = 1'b0;
`endif

    assign push     = accept && !bypass;
    assign read_win = rd_req && (count < CNT_W'(DEPTH)) && !rst;
    assign do_pop   = !read_win && (count != '0);

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_two  (in_pair),
        .num0      (in_num),
        .data0     (in_data),
        .num1      (in_num ^ 2'b01),
        .data1     (in_data_hi),
        .pop       (do_pop),
        .count     (count),
        .count_nxt (count_nxt),
        .head_num  (head_num),
        .head_data (head_data),
        .head_hi   (head_hi)
    );

    always_comb begin
        wtype    = WB_NONE;
        wb_num1  = rd_num1;
        wb_num2  = rd_num2;
        wb_data  = '0;
        rd_grant = 1'b0;
        if (read_win) begin
            rd_grant = 1'b1;
        end else if (do_pop) begin
            wb_data = head_data;
            if (head_hi) begin
                wtype   = WB_HI;
                wb_num2 = head_num;
            end else begin
                wtype   = WB_LO;
                wb_num1 = head_num;
            end
        end else if (bypass) begin
            wtype   = WB_LO;
            wb_num1 = in_num;
            wb_data = in_data;
        end
    end

    assign wb_write = wtype;

    // A pair targets num and num^1, so each register sees at most one increment.
    always_comb begin
        sb_inc = '0;
        sb_dec = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            sb_inc[r] = push && ((in_num == reg_idx_t'(r)) ||
                                 (in_pair && ((in_num ^ 2'b01) == reg_idx_t'(r))));
            sb_dec[r] = do_pop && (head_num == reg_idx_t'(r));
            sb_nxt[r] = sb_cnt[r];
            if (sb_inc[r] && !sb_dec[r])
                sb_nxt[r] = sb_cnt[r] + CNT_W'(1);
            else if (sb_dec[r] && !sb_inc[r])
                sb_nxt[r] = sb_cnt[r] - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < 4; r++)
                sb_cnt[r] <= '0;
            pending  <= '0;
            in_ready <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < 4; r++) begin
                sb_cnt[r]  <= sb_nxt[r];
                pending[r] <= (sb_nxt[r] != '0);
            end
            in_ready <= (count_nxt <= CNT_W'(DEPTH - 2));
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_reg_writeback;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_num;
    logic [15:0] in_data;
    logic        in_pair;
    logic [15:0] in_data_hi;
    logic        rd_req;
    logic [1:0]  rd_num1;
    logic [1:0]  rd_num2;
    logic        rd_grant;
    logic [15:0] wb_data;
    logic [1:0]  wb_write;
    logic [1:0]  wb_num1;
    logic [1:0]  wb_num2;
    logic [3:0]  pending;

    always #5 clk = ~clk;

    reg_writeback #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_num     (in_num),
        .in_data    (in_data),
        .in_pair    (in_pair),
        .in_data_hi (in_data_hi),
        .rd_req     (rd_req),
        .rd_num1    (rd_num1),
        .rd_num2    (rd_num2),
        .rd_grant   (rd_grant),
        .wb_data    (wb_data),
        .wb_write   (wb_write),
        .wb_num1    (wb_num1),
        .wb_num2    (wb_num2),
        .pending    (pending)
    );

    typedef struct {
        bit [1:0]  num;
        bit [15:0] data;
        bit        hi;
    } ent_t;

    ent_t q[$];
    bit   m_ready;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input bit [1:0] num, input bit [15:0] data,
                         input bit pair, input bit [15:0] hi, input bit rq,
                         input bit [1:0] n1, input bit [1:0] n2);
        in_valid   = v;
        in_num     = num;
        in_data    = data;
        in_pair    = pair;
        in_data_hi = hi;
        rd_req     = rq;
        rd_num1    = n1;
        rd_num2    = n2;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 2'd3, 2'd1);
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic tick();
        bit       acc, rd_win, wr, byp;
        bit [3:0] exp_p;
        ent_t     h, e;
        #1;
        acc    = in_valid && m_ready;
        rd_win = rd_req && (q.size() < DEPTH);
        wr     = !rd_win && (q.size() > 0);
        byp    = 1'b0;
`ifdef WB_BYPASS_EN
        byp = (q.size() == 0) && acc && !rd_req && !in_pair;
`endif
        exp_p = '0;
        foreach (q[i]) exp_p[q[i].num] = 1'b1;
        chk("in_ready", in_ready, m_ready);
        chk("pending", pending, exp_p);
        chk("rd_grant", rd_grant, rd_win);
        if (wr) begin
            h = q[0];
            chk("wb_write", wb_write, h.hi ? 2'b10 : 2'b01);
            chk("wb_data", wb_data, h.data);
            if (h.hi) chk("wb_num2_hi", wb_num2, h.num);
            else      chk("wb_num1_lo", wb_num1, h.num);
        end else if (byp) begin
            chk("wb_write_byp", wb_write, 2'b01);
            chk("wb_data_byp", wb_data, in_data);
            chk("wb_num1_byp", wb_num1, in_num);
        end else begin
            chk("wb_write_none", wb_write, 2'b00);
            chk("wb_num1_rd", wb_num1, rd_num1);
            chk("wb_num2_rd", wb_num2, rd_num2);
        end
        @(posedge clk);
        if (wr) void'(q.pop_front());
        if (acc && !byp) begin
            e.num = in_num; e.data = in_data; e.hi = 1'b0;
            q.push_back(e);
            if (in_pair) begin
                e.num = in_num ^ 2'b01; e.data = in_data_hi; e.hi = 1'b1;
                q.push_back(e);
            end
        end
        m_ready = (DEPTH - q.size()) >= 2;
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1, 2'd1, 16'h1234, 1, 16'h5678, 1, 2'd2, 2'd3);
        rst = 1'b1;
        #1;
        chk("rst_pending", pending, 4'b0000);
        chk("rst_wb_write", wb_write, 2'b00);
        chk("rst_wb_data", wb_data, 16'h0000);
        chk("rst_rd_grant", rd_grant, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        q.delete();
        m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle();
        @(posedge clk);
        @(negedge clk);
        m_ready = 1'b1;
    endtask

    task automatic drain();
        idle();
        for (int k = 0; k < 3 * DEPTH && q.size() > 0; k++) tick();
        tick();
    endtask

    task automatic rand_cycles(input int n, input int rd_pct);
        for (int k = 0; k < n; k++) begin
            drive($urandom_range(0, 1), 2'($urandom), 16'($urandom), $urandom_range(0, 2) == 0,
                  16'($urandom), $urandom_range(0, 99) < rd_pct, 2'($urandom), 2'($urandom));
            tick();
        end
    endtask

    initial begin
        idle();
        #2;
        do_reset();

        // Single result.
        drive(1, 2'd2, 16'hBEEF, 0, 16'h0, 0, 2'd0, 2'd0);
        tick();
        idle();
        repeat (3) tick();

        // Pair result.
        drive(1, 2'd1, 16'h1111, 1, 16'h2222, 0, 2'd0, 2'd0);
        tick();
        idle();
        repeat (4) tick();

        // Reads held high while two pairs fill the queue; full forces writes.
        drive(1, 2'd0, 16'hA0A0, 1, 16'hA1A1, 1, 2'd1, 2'd2);
        tick();
        drive(1, 2'd2, 16'hB0B0, 1, 16'hB1B1, 1, 2'd3, 2'd0);
        tick();
        for (int k = 0; k < 8; k++) begin
            drive(1, 2'($urandom), 16'($urandom), 0, 16'h0, 1, 2'($urandom), 2'($urandom));
            tick();
        end
        drain();

        // Same destination back to back, overlapping with its own write.
        drive(1, 2'd3, 16'h3333, 0, 16'h0, 0, 2'd0, 2'd0);
        tick();
        drive(1, 2'd3, 16'h3334, 0, 16'h0, 1, 2'd0, 2'd0);
        tick();
        drive(1, 2'd3, 16'h3335, 0, 16'h0, 1, 2'd1, 2'd1);
        tick();
        drain();

        rand_cycles(300, 30);
        rand_cycles(150, 80);
        drain();

        // Reset after the low word of a pair has been written.
        drive(1, 2'd2, 16'hCAFE, 1, 16'hF00D, 0, 2'd0, 2'd0);
        tick();
        idle();
        tick();
        do_reset();
        idle();
        repeat (3) tick();

        rand_cycles(100, 40);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-back sequencer that drives the write side of the 4 x 16-bit register file and shares its two address ports with the decode stage's read requests. Results arrive from the ALU/multiplier over a valid/ready handshake. They are queued and retired one register write per cycle. A per-register pending scoreboard lets decode detect read-after-write hazards. The block sits between the execute stage and the register file, arbitrating the shared `num1`/`num2` ports each cycle between a read and a write.

## Interface
- `DEPTH`, default 4: queue entries, each holding one 16-bit word; a power of 2, at least 2.
- `WIDTH`, default 16: data width; matches the register file.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: a result is offered.
- `in_ready` out 1: the block can accept a result; asserted when at least 2 slots are free.
- `in_num` in 2: destination register.
- `in_data` in WIDTH: low or only word.
- `in_pair` in 1: 32-bit result; `in_data_hi` goes to register `in_num^1`.
- `in_data_hi` in WIDTH: high word; ignored unless `in_pair`.
- `rd_req` in 1: decode wants the read ports this cycle.
- `rd_num1`, `rd_num2` in 2 each: decode read addresses.
- `rd_grant` out 1: register file outputs are valid this cycle.
- `wb_data` out WIDTH: drives the register file `bus_in`.
- `wb_write` out 2: register file write strobes; at most one bit set.
- `wb_num1`, `wb_num2` out 2 each: drive the register file `num1`/`num2`.
- `pending` out 4: bit r set while any queued write targets register r.

## Operation
- **Accept:** an input is taken when `in_valid && in_ready` at the clock edge.
  - Single result: pushes 1 entry {num, data, hi=0}.
  - Pair result: pushes 2 entries in order, {num, data, hi=0} then {num^1, data_hi, hi=1}.
- **Queue:** a circular FIFO of DEPTH entries with head/tail pointers that wrap modulo DEPTH and an occupancy count.
- **Arbitration, evaluated every cycle:**
  - If `rd_req` is high and count < DEPTH: the read wins. `rd_grant` = 1, `wb_write` = 0, `wb_num1`/`wb_num2` = `rd_num1`/`rd_num2`.
  - Otherwise, if count > 0: the head write issues and the head pops.
    - Entry with hi=0: `wb_write` = 01, `wb_num1` = entry num.
    - Entry with hi=1: `wb_write` = 10, `wb_num2` = entry num.
    - `wb_data` = entry data in both cases.
    - `rd_grant` = 0.
  - A full queue forces the write even if `rd_req` is high; this guarantees forward progress.
  - Idle (no read, no write): `wb_write` = 0 and the num outputs follow `rd_num*`.
- **Scoreboard:**
  - Per-register counters, 3 bits wide (range 0..DEPTH).
  - A counter increments per accepted entry targeting that register and decrements when that register's write issues.
  - An increment and a decrement in the same cycle leave the counter unchanged.
  - Both words of a pair update their respective registers' counters.
  - `pending[r]` = (counter r != 0).
- **Reset (any time, including mid-pair):**
  - Queue empties and all counters clear to 0.
  - `pending` = 0, `wb_write` = 0, `wb_data` = 0, `rd_grant` = 0.
  - `in_ready` = 0 while `rst` is high, and 1 from the first cycle after release.

## Timing
- Without `WB_BYPASS_EN`, an accepted entry becomes the head no earlier than the next cycle. Minimum accept-to-write latency is 1 cycle for the first word and 2 cycles for a pair's high word.
- `rd_grant`, `wb_write`, `wb_num*` and `wb_data` are combinational from the queue head, the count and `rd_req`. The queue, count and counters are registered.
- `pending` is registered. It rises the cycle after accept and falls the cycle after the last write issues.
- `in_ready` is registered from the count and does not depend on `in_pair`.
- Throughput: one register write per cycle when `rd_req` is low.

## Configuration
- `WB_BYPASS_EN` defined:
  - Applies when the queue is empty, `in_valid && in_ready` holds, `rd_req` is low and `in_pair` is 0.
  - The write issues in the same cycle with `wb_write` = 01, `wb_num1` = `in_num`, `wb_data` = `in_data`.
  - Nothing is pushed and `pending` never rises for that write.
  - Pairs always use the queue.
- `WB_BYPASS_EN` undefined: all writes go through the queue and the minimum latency is 1 cycle.

## Structure
- Shared package holds:
  - The register index type (2 bits).
  - The data word type.
  - The queue entry struct {num, data, hi}.
  - The `wb_write` encodings NONE=00, LO=01, HI=10.
- One sub-module, `wb_fifo`: a parameterised circular queue with push2 (single or double) and pop, exposing count and head.
- Arbitration and the scoreboard live in `reg_writeback`.

## Test plan
- **Single result:** reset, then push num=2 data=16'hBEEF with `rd_req`=0.
  - Next cycle: `wb_write`=01, `wb_num1`=2, `wb_data`=BEEF.
  - `pending[2]` is 1 for exactly one cycle, then 0.
- **Pair result:** push in_pair num=1 data=1111 hi=2222.
  - Two consecutive writes: (01, num1=1, 1111), then (10, num2=0, 2222).
  - `pending` = 0011 during the writes, clearing afterwards.
- **Read priority and full override:** fill the queue (DEPTH=4 via two pairs) with `rd_req` held high.
  - Once count=4: a write is forced, `rd_grant`=0 that cycle, and `in_ready`=0 while fewer than 2 slots are free.
- **Same-register scoreboard:** push num=3 twice.
  - Counter 3 reaches 2; `pending[3]` stays 1 until the second write issues.
  - Accepting num=3 in the same cycle a num=3 write issues keeps `pending[3]`=1.
- **Reset mid-pair:** assert `rst` after the low word of a pair is written.
  - The high word is never written; `pending`=0 and `wb_write`=0 immediately.
  - `in_ready`=1 the cycle after release.
- **With `WB_BYPASS_EN`:** push num=0 data=00AA into an empty queue with `rd_req`=0.
  - Same-cycle `wb_write`=01, `wb_data`=00AA; `pending[0]` never set.
